// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction memory fetch port
package imem_pkg;

  localparam int IMEM_XLEN = 64;
  localparam int IMEM_ILEN = 32;

  localparam logic [IMEM_ILEN-1:0] ILLEGAL_INSN = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } fault_e;

  // Buffered response tuple; widths follow the package defaults used by the top.
  typedef struct packed {
    logic [IMEM_ILEN-1:0] insn;
    logic [IMEM_XLEN-1:0] addr;
    fault_e               fault;
  } fetch_rsp_t;

endpackage

// File: rtl/imem_fetch_port_if.sv
// rtl/imem_fetch_port_if.sv - fetch request/response, flush and program-load signal bundle
interface imem_fetch_port_if #(
  parameter int XLEN  = 64,
  parameter int ILEN  = 32,
  parameter int IDX_W = 5
);

  logic             req_valid;
  logic             req_ready;
  logic [XLEN-1:0]  req_addr;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [ILEN-1:0]  rsp_insn;
  logic [XLEN-1:0]  rsp_addr;
  logic [1:0]       rsp_fault;
  logic             flush;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [ILEN-1:0]  wr_data;

  modport master (
    output req_valid, req_addr, rsp_ready, flush, wr_en, wr_idx, wr_data,
    input  req_ready, rsp_valid, rsp_insn, rsp_addr, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, flush, wr_en, wr_idx, wr_data,
    output req_ready, rsp_valid, rsp_insn, rsp_addr, rsp_fault
  );

endinterface

// File: rtl/fetch_rsp_fifo.sv
// rtl/fetch_rsp_fifo.sv - two-entry in-order response buffer with flush
module fetch_rsp_fifo
  import imem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  fetch_rsp_t push_data,
  input  logic       pop,
  input  logic       flush,
  output logic [1:0] count,
  output fetch_rsp_t head
);

  fetch_rsp_t slots [2];
  logic       wr_ptr;
  logic       rd_ptr;

  // Caller guarantees push only when count < 2 and pop only when count > 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slots[0] <= '0;
      slots[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        slots[wr_ptr] <= push_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head = slots[rd_ptr];

endmodule

// File: rtl/imem_fetch_port.sv
// rtl/imem_fetch_port.sv - runtime-loadable instruction memory with buffered, fault-checked fetch
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int              XLEN         = IMEM_XLEN,
  parameter int              ILEN         = IMEM_ILEN,
  parameter int              DEPTH        = 32,
  parameter logic [ILEN-1:0] ILLEGAL_INSN = imem_pkg::ILLEGAL_INSN
) (
  input logic               clk,
  input logic               rst_n,
  imem_fetch_port_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [ILEN-1:0]  mem [DEPTH];
  logic [XLEN-3:0]  word_addr;
  logic [IDX_W-1:0] rd_idx;
  logic             misalign;
  logic             out_of_range;
  logic             push;
  logic             pop;
  logic [1:0]       count;
  fetch_rsp_t       push_data;
  fetch_rsp_t       head;

  assign word_addr    = bus.req_addr[XLEN-1:2];
  assign rd_idx       = bus.req_addr[IDX_W+1:2];
  assign misalign     = (bus.req_addr[1:0] != 2'b00);
  // Full-width compare so addresses beyond DEPTH never alias onto low words.
  assign out_of_range = (word_addr >= (XLEN-2)'(DEPTH));

  assign bus.req_ready = rst_n && !bus.flush && (count < 2'd2);
  assign push          = bus.req_valid && bus.req_ready;
  assign pop           = bus.rsp_valid && bus.rsp_ready;

  always_comb begin
    push_data.addr  = bus.req_addr;
    push_data.insn  = ILLEGAL_INSN;
    push_data.fault = FAULT_NONE;
    if (misalign) begin
      push_data.fault = FAULT_MISALIGN;
    end else if (out_of_range) begin
      push_data.fault = FAULT_RANGE;
    end else begin
      push_data.insn = mem[rd_idx];
    end
  end

  // Memory is intentionally not reset so a loaded image survives reset.
  always_ff @(posedge clk) begin
    if (rst_n && bus.wr_en) begin
      mem[bus.wr_idx] <= bus.wr_data;
    end
  end

  fetch_rsp_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.flush),
    .count     (count),
    .head      (head)
  );

  assign bus.rsp_valid = (count != 2'd0);
  assign bus.rsp_insn  = head.insn;
  assign bus.rsp_addr  = head.addr;
  assign bus.rsp_fault = head.fault;

endmodule

// File: doc/imem_fetch_port.md
Name: imem_fetch_port

Overview:
- Parametrised instruction memory with a valid/ready fetch request and response interface.
- Sits between the fetch stage PC logic and decode.
- Word storage is loadable at runtime through a write port, so program images are no longer hard-coded.
- Adds alignment and range fault reporting, a 2-entry response buffer for decode back-pressure, and a flush for redirects.

Parameters:
- XLEN, 64, width of the fetch byte address.
- ILEN, 32, instruction word width.
- DEPTH, 32, number of instruction words. Power of two, minimum 2.
- IDX_W, $clog2(DEPTH), word index width (derived).
- ILLEGAL_INSN, 32'hFFFF_FFFF, data returned for any faulting fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  fetch request accepted when high together with req_valid.
- req_addr  in  XLEN  byte address of the requested instruction.
- rsp_valid  out  1  response available at buffer head.
- rsp_ready  in  1  consumer takes the head entry.
- rsp_insn  out  ILEN  instruction word, or ILLEGAL_INSN on fault.
- rsp_addr  out  XLEN  req_addr echoed for this response.
- rsp_fault  out  2  fault code: 00 none, 01 misaligned, 10 out of range.
- flush  in  1  discard all buffered responses.
- wr_en  in  1  program-load write strobe.
- wr_idx  in  IDX_W  word index to write.
- wr_data  in  ILEN  word to write.

Behaviour:
- Reset, sampled on rising clk while rst_n=0:
  - Buffer count is 0 and pointers are 0, so rsp_valid=0.
  - Buffer storage is cleared, so rsp_insn=0, rsp_addr=0, rsp_fault=00.
  - req_ready=0 during the reset cycle, and 1 on the first cycle after reset deasserts.
  - Memory array is NOT reset; contents persist across reset.
- Accept: a request is accepted on the edge where req_valid && req_ready.
- req_ready = rst_n && !flush && (count < 2). It is a function of registered state plus flush only; no combinational path from rsp_ready.
- Lookup on accept, evaluated against the memory contents before that edge:
  - Misaligned if req_addr[1:0] != 0. Result is fault 01, ILLEGAL_INSN. Takes priority over range.
  - Out of range if req_addr[XLEN-1:2] >= DEPTH. Result is fault 10, ILLEGAL_INSN.
  - Otherwise fault 00, data = mem[req_addr[IDX_W+1:2]].
  - The {insn, addr, fault} tuple is pushed into the buffer.
- Latency: an accepted request is visible at rsp_valid on the cycle after the accept edge, provided the buffer is empty or earlier entries drain first. Responses stay in strict request order.
- Pop: the head is removed on the edge where rsp_valid && rsp_ready. Push and pop on the same edge leave count unchanged. When count=1, the pushed entry becomes the new head.
- Buffer: 2 entries.
  - Full (count=2) drives req_ready=0, even if rsp_ready=1 that cycle.
  - Empty drives rsp_valid=0.
  - Outputs hold stable while rsp_valid && !rsp_ready.
- Flush: on the edge where flush=1, count goes to 0 and a simultaneous pop has no extra effect. No request is accepted in a flush cycle. rsp_valid=0 on the next cycle.
- Write port:
  - On an edge with wr_en=1, mem[wr_idx] <= wr_data.
  - wr_idx >= DEPTH is ignored; this only occurs when DEPTH is not a power of two, which the parameter rule forbids.
  - A write and an accept to the same word on the same edge: the response carries the OLD data (read-before-write). The next fetch sees the new data.
  - Writes are independent of flush and of buffer state. Writes during reset are ignored.
- Reset mid-operation: buffered responses are lost. The consumer must not expect responses to requests accepted before reset.
- Width rules:
  - The range compare uses the full XLEN-2 upper bits; no truncation aliasing, so address 32*4 must fault at DEPTH=32.
  - rsp_addr is an exact copy of req_addr.

Decomposition:
- Package imem_pkg holds:
  - the fault_e enum (FAULT_NONE=2'b00, FAULT_MISALIGN=2'b01, FAULT_RANGE=2'b10);
  - a packed struct fetch_rsp_t {insn, addr, fault};
  - the ILLEGAL_INSN default constant.
- One sub-module, fetch_rsp_fifo: a 2-entry FIFO of fetch_rsp_t with push, pop, flush, count, synchronous active-low reset.
- The top holds the memory array, address decode, fault logic and write port.

Test Plan:
- Load 0x00A00093 at idx 0 and 0x00108133 at idx 1. Fetch addr 0 then 4 back-to-back with rsp_ready=1. Expect rsp_valid one cycle after each accept, rsp_insn 0x00A00093 then 0x00108133, fault 00, rsp_addr 0 then 4.
- Fetch addr 6, then addr 128 (DEPTH=32). Expect ILLEGAL_INSN with fault 01, then ILLEGAL_INSN with fault 10; rsp_addr echoes 6 and 128.
- Hold rsp_ready=0 and issue 3 requests. Expect 2 accepts, then req_ready=0, outputs stable. Release rsp_ready and expect in-order drain, with req_ready returning the cycle after the first pop.
- With 2 entries buffered, assert flush together with req_valid. Expect no accept that cycle and rsp_valid=0 next cycle. A later fetch of idx 0 returns correct data.
- Write idx 3 = 0xDEADBEEF on the same edge a fetch of addr 12 is accepted. Expect the old word; a subsequent fetch of addr 12 returns 0xDEADBEEF.
- Assert rst_n=0 with one response buffered. Expect rsp_valid=0 and rsp_insn=0 after the edge. The memory word written before reset is still returned after reset.
